// File: rtl/dpi_stream_sequencer.sv
// Packet sequencer for one regex-matcher slice: restores per-stream state,
// streams payload bytes, closes the packet with eop and reports the match flag.
module dpi_stream_sequencer #(
    parameter int   NSTREAM = 64,
    parameter int   SID_W   = 6,
    parameter int   DRAIN   = 2,
    parameter logic EN_RST  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pkt_valid,
    output logic             pkt_ready,
    input  logic [7:0]       pkt_data,
    input  logic             pkt_sop,
    input  logic             pkt_eop,
    input  logic [SID_W-1:0] pkt_sid,
    input  logic             cfg_wr,
    input  logic [SID_W-1:0] cfg_sid,
    input  logic             cfg_en,
    input  logic             cfg_clear,
    output logic             load_state,
    output logic [SID_W-1:0] stream_id,
    output logic             new_stream_id,
    output logic             enable,
    output logic [7:0]       char_in,
    output logic             char_in_vld,
    output logic             eop,
    input  logic             fired,
    output logic             res_valid,
    output logic [SID_W-1:0] res_sid,
    output logic             res_fired,
    output logic             err_sop,
    output logic [15:0]      drop_cnt
);

    localparam int CNT_W = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_GAP    = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4,
        S_EOP    = 3'd5,
        S_RESULT = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic               live_q, live_d;
    logic [NSTREAM-1:0] seen_q, seen_d;
    logic [NSTREAM-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic               first_done_q, first_done_d;
    logic               load_state_q, load_state_d;
    logic [SID_W-1:0]   stream_id_q, stream_id_d;
    logic               new_stream_id_q, new_stream_id_d;
    logic               enable_q, enable_d;
    logic               eop_q, eop_d;
    logic               res_valid_q, res_valid_d;
    logic [SID_W-1:0]   res_sid_q, res_sid_d;
    logic               res_fired_q, res_fired_d;
    logic               err_sop_q, err_sop_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;
    logic               pkt_ready_s;
    logic               char_vld_s;
    logic               close_s;

    // Next-state, per-stream tables and handshake decode
    always_comb begin
        state_d         = state_q;
        live_d          = 1'b1;
        drain_cnt_d     = drain_cnt_q;
        first_done_d    = first_done_q;
        load_state_d    = 1'b0;
        stream_id_d     = stream_id_q;
        new_stream_id_d = new_stream_id_q;
        enable_d        = enable_q;
        eop_d           = 1'b0;
        res_valid_d     = 1'b0;
        res_sid_d       = res_sid_q;
        res_fired_d     = res_fired_q;
        err_sop_d       = 1'b0;
        drop_cnt_d      = drop_cnt_q;
        pkt_ready_s     = 1'b0;
        char_vld_s      = 1'b0;
        close_s         = 1'b0;
        mask_d          = mask_q;
        if (cfg_clear) begin
            seen_d = '0;
        end else begin
            seen_d = seen_q;
        end
        if (cfg_wr) begin
            mask_d[cfg_sid] = cfg_en;
        end else begin
            mask_d = mask_q;
        end

        case (state_q)
            S_IDLE: begin
                // A sop beat is held in the FIFO; it is consumed later as data
                pkt_ready_s = live_q & ~(pkt_valid & pkt_sop);
                if (live_q && pkt_valid && pkt_sop) begin
                    state_d         = S_LOAD;
                    load_state_d    = 1'b1;
                    stream_id_d     = pkt_sid;
                    new_stream_id_d = ~(seen_q[pkt_sid] & ~cfg_clear);
                    enable_d        = (cfg_wr && (cfg_sid == pkt_sid)) ? cfg_en : mask_q[pkt_sid];
                end else if (live_q && pkt_valid && (drop_cnt_q != 16'hFFFF)) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end else begin
                    drop_cnt_d = drop_cnt_q;
                end
            end
            S_LOAD: begin
                seen_d[stream_id_q] = 1'b1;
                first_done_d        = 1'b0;
                state_d             = S_GAP;
            end
            S_GAP: begin
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (pkt_valid && pkt_sop && first_done_q) begin
                    err_sop_d = 1'b1;
                    close_s   = 1'b1;
                end else begin
                    pkt_ready_s = 1'b1;
                    if (pkt_valid) begin
                        char_vld_s   = 1'b1;
                        first_done_d = 1'b1;
                        close_s      = pkt_eop;
                    end else begin
                        char_vld_s = 1'b0;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d = S_EOP;
                    eop_d   = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q - CNT_W'(1);
                end
            end
            S_EOP: begin
                state_d     = S_RESULT;
                res_valid_d = 1'b1;
                res_sid_d   = stream_id_q;
                res_fired_d = fired & enable_q;
            end
            S_RESULT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (close_s && (DRAIN == 0)) begin
            state_d = S_EOP;
            eop_d   = 1'b1;
        end else if (close_s) begin
            state_d     = S_DRAIN;
            drain_cnt_d = CNT_W'(DRAIN - 1);
        end else begin
            drain_cnt_d = drain_cnt_d;
        end
    end

    // State, tables and registered slice/result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            live_q          <= 1'b0;
            seen_q          <= '0;
            mask_q          <= {NSTREAM{EN_RST}};
            drain_cnt_q     <= '0;
            first_done_q    <= 1'b0;
            load_state_q    <= 1'b0;
            stream_id_q     <= '0;
            new_stream_id_q <= 1'b0;
            enable_q        <= 1'b0;
            eop_q           <= 1'b0;
            res_valid_q     <= 1'b0;
            res_sid_q       <= '0;
            res_fired_q     <= 1'b0;
            err_sop_q       <= 1'b0;
            drop_cnt_q      <= 16'd0;
        end else begin
            state_q         <= state_d;
            live_q          <= live_d;
            seen_q          <= seen_d;
            mask_q          <= mask_d;
            drain_cnt_q     <= drain_cnt_d;
            first_done_q    <= first_done_d;
            load_state_q    <= load_state_d;
            stream_id_q     <= stream_id_d;
            new_stream_id_q <= new_stream_id_d;
            enable_q        <= enable_d;
            eop_q           <= eop_d;
            res_valid_q     <= res_valid_d;
            res_sid_q       <= res_sid_d;
            res_fired_q     <= res_fired_d;
            err_sop_q       <= err_sop_d;
            drop_cnt_q      <= drop_cnt_d;
        end
    end

    assign pkt_ready     = pkt_ready_s;
    assign char_in_vld   = char_vld_s;
    assign char_in       = char_vld_s ? pkt_data : 8'd0;
    assign load_state    = load_state_q;
    assign stream_id     = stream_id_q;
    assign new_stream_id = new_stream_id_q;
    assign enable        = enable_q;
    assign eop           = eop_q;
    assign res_valid     = res_valid_q;
    assign res_sid       = res_sid_q;
    assign res_fired     = res_fired_q;
    assign err_sop       = err_sop_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Directed and randomized bench for dpi_stream_sequencer with a packet-level model.
module tb_dpi_stream_sequencer;

    localparam int SID_W = 6;
    localparam int NS    = 64;
    localparam int DR    = 2;

    typedef logic [7:0] bq_t [$];
    typedef struct { int cyc; int sid; int nw; int en; } ld_t;
    typedef struct { int cyc; int dat; } ch_t;
    typedef struct { int cyc; int sid; int fr; } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic pkt_valid = 1'b0, pkt_sop = 1'b0, pkt_eop = 1'b0;
    logic [7:0] pkt_data = 8'd0;
    logic [SID_W-1:0] pkt_sid = '0, cfg_sid = '0;
    logic cfg_wr = 1'b0, cfg_en = 1'b0, cfg_clear = 1'b0, fired = 1'b0;
    logic pkt_ready, load_state, new_stream_id, enable, char_in_vld, eop;
    logic res_valid, res_fired, err_sop;
    logic [SID_W-1:0] stream_id, res_sid;
    logic [7:0] char_in;
    logic [15:0] drop_cnt;

    dpi_stream_sequencer #(.NSTREAM(NS), .SID_W(SID_W), .DRAIN(DR), .EN_RST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_data(pkt_data), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop), .pkt_sid(pkt_sid),
        .cfg_wr(cfg_wr), .cfg_sid(cfg_sid), .cfg_en(cfg_en), .cfg_clear(cfg_clear),
        .load_state(load_state), .stream_id(stream_id), .new_stream_id(new_stream_id),
        .enable(enable), .char_in(char_in), .char_in_vld(char_in_vld), .eop(eop),
        .fired(fired), .res_valid(res_valid), .res_sid(res_sid), .res_fired(res_fired),
        .err_sop(err_sop), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, err_cnt = 0, viol = 0;
    ld_t  ld_q[$];
    ch_t  ch_q[$];
    int   eop_q[$];
    res_t res_q[$];
    bit   seen_m[NS];
    bit   en_m[NS];

    always @(posedge clk) cyc <= cyc + 1;

    // Record slice/result events with their cycle stamps
    always @(negedge clk) begin
        if (load_state) ld_q.push_back('{cyc, int'(stream_id), int'(new_stream_id), int'(enable)});
        if (char_in_vld) ch_q.push_back('{cyc, int'(char_in)});
        if (eop) eop_q.push_back(cyc);
        if (res_valid) res_q.push_back('{cyc, int'(res_sid), int'(res_fired)});
        if (err_sop) err_cnt <= err_cnt + 1;
        if ((load_state && eop) || (char_in_vld && !pkt_valid)) viol <= viol + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        foreach (seen_m[i]) begin
            seen_m[i] = 1'b0;
            en_m[i]   = 1'b1;
        end
        ld_q.delete(); ch_q.delete(); eop_q.delete(); res_q.delete();
    endtask

    task automatic send_beat(input logic [7:0] d, input bit sop, input bit eo, input int sid);
        bit acc;
        acc = 1'b0;
        pkt_valid = 1'b1; pkt_data = d; pkt_sop = sop; pkt_eop = eo; pkt_sid = SID_W'(sid);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            acc = pkt_ready;
            tick();
            if (acc) break;
        end
        if (!acc) chk("beat_accept", acc, 1);
    endtask

    task automatic send_pkt(input int sid, input bq_t b, input bit bub);
        foreach (b[i]) begin
            send_beat(b[i], i == 0, i == b.size() - 1, sid);
            if (bub && (i != b.size() - 1) && ($urandom_range(0, 1) == 1)) begin
                pkt_valid = 1'b0;
                tick();
            end
        end
        pkt_valid = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0;
    endtask

    task automatic wait_res(input int n);
        for (int k = 0; k < 40; k++) begin
            if (res_q.size() >= n) break;
            tick();
        end
    endtask

    task automatic cfg_write(input int sid, input bit en, input bit clr);
        cfg_wr = 1'b1; cfg_sid = SID_W'(sid); cfg_en = en; cfg_clear = clr;
        tick();
        cfg_wr = 1'b0; cfg_clear = 1'b0;
        en_m[sid] = en;
        if (clr) foreach (seen_m[i]) seen_m[i] = 1'b0;
    endtask

    task automatic verify_pkt(input int sid, input bq_t b, input bit fv, input bit trunc);
        ld_t l; ch_t c; res_t r; int e, last_c;
        bit exp_new, exp_en;
        exp_new = !seen_m[sid];
        seen_m[sid] = 1'b1;
        exp_en = en_m[sid];
        if (ld_q.size() == 0) begin chk("load_seen", ld_q.size(), 1); return; end
        l = ld_q.pop_front();
        chk("load_sid", l.sid, sid);
        chk("new_stream_id", l.nw, exp_new);
        chk("enable", l.en, exp_en);
        last_c = l.cyc;
        foreach (b[i]) begin
            if (ch_q.size() == 0) begin chk("char_seen", ch_q.size(), 1); return; end
            c = ch_q.pop_front();
            chk("char_in", c.dat, b[i]);
            if (i == 0) chk("first_char_lat", c.cyc - l.cyc, 2);
            last_c = c.cyc;
        end
        if (eop_q.size() == 0) begin chk("eop_seen", eop_q.size(), 1); return; end
        e = eop_q.pop_front();
        if (!trunc) chk("eop_lat", e - last_c, DR + 1);
        if (res_q.size() == 0) begin chk("res_seen", res_q.size(), 1); return; end
        r = res_q.pop_front();
        chk("res_lat", r.cyc - e, 1);
        chk("res_sid", r.sid, sid);
        chk("res_fired", r.fr, fv & exp_en);
    endtask

    initial begin
        bq_t b, b2;
        int sid, len, pre_err;
        bit fv, bub;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pkt_ready", pkt_ready, 0);
        chk("rst_load_state", load_state, 0);
        chk("rst_char_vld", char_in_vld, 0);
        chk("rst_eop", eop, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_stream_id", stream_id, 0);
        rst_n = 1'b1;
        tick(); tick();

        // sid 5 "abc": first-time stream, full latency profile
        b = '{8'h61, 8'h62, 8'h63};
        send_pkt(5, b, 1'b0); wait_res(1); verify_pkt(5, b, 1'b0, 1'b0);
        send_pkt(5, b, 1'b0); wait_res(1); verify_pkt(5, b, 1'b0, 1'b0);
        cfg_write(0, 1'b1, 1'b1);
        send_pkt(5, b, 1'b0); wait_res(1); verify_pkt(5, b, 1'b0, 1'b0);

        // enable mask gates the fired flag
        fired = 1'b1;
        cfg_write(3, 1'b0, 1'b0);
        b = '{8'h10, 8'h20};
        send_pkt(3, b, 1'b0); wait_res(1); verify_pkt(3, b, 1'b1, 1'b0);
        cfg_write(3, 1'b1, 1'b0);
        send_pkt(3, b, 1'b0); wait_res(1); verify_pkt(3, b, 1'b1, 1'b0);
        fired = 1'b0;

        // beats without sop in IDLE are dropped
        pkt_valid = 1'b1; pkt_sop = 1'b0; pkt_data = 8'h77;
        repeat (3) tick();
        pkt_valid = 1'b0;
        tick();
        chk("drop_cnt", drop_cnt, 3);
        chk("drop_no_load", ld_q.size(), 0);
        chk("drop_no_char", ch_q.size(), 0);

        // sop mid-packet closes sid 1 and restarts as sid 2
        pre_err = err_cnt;
        b = '{8'h78, 8'h79};
        b2 = '{8'h70, 8'h71};
        send_beat(b[0], 1'b1, 1'b0, 1);
        send_beat(b[1], 1'b0, 1'b0, 1);
        send_pkt(2, b2, 1'b0); wait_res(2);
        chk("err_sop_pulses", err_cnt - pre_err, 1);
        verify_pkt(1, b, 1'b0, 1'b1);
        verify_pkt(2, b2, 1'b0, 1'b0);

        // randomized packets, bubbles and config traffic
        for (int p = 0; p < 20; p++) begin
            if ($urandom_range(0, 3) == 0)
                cfg_write(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0));
            sid = int'($urandom_range(0, 7));
            len = int'($urandom_range(1, 5));
            b.delete();
            for (int i = 0; i < len; i++) b.push_back(8'($urandom_range(0, 255)));
            fv = 1'($urandom_range(0, 1));
            bub = 1'($urandom_range(0, 1));
            fired = fv;
            send_pkt(sid, b, bub); wait_res(1);
            verify_pkt(sid, b, fv, 1'b0);
        end
        fired = 1'b0;
        chk("no_extra_chars", ch_q.size(), 0);

        // async reset mid-STREAM
        send_beat(8'h11, 1'b1, 1'b0, 9);
        pkt_valid = 1'b1; pkt_sop = 1'b0; pkt_data = 8'h22;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_pkt_ready", pkt_ready, 0);
        chk("midrst_char_vld", char_in_vld, 0);
        chk("midrst_char_in", char_in, 0);
        chk("midrst_drop_cnt", drop_cnt, 0);
        chk("midrst_stream_id", stream_id, 0);
        pkt_valid = 1'b0;
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        tick(); tick();
        b = '{8'h33, 8'h44};
        send_pkt(9, b, 1'b0); wait_res(1); verify_pkt(9, b, 1'b0, 1'b0);
        chk("invariants", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
